mpc_chan_bank_arb: RTL

- Sits between the NCH requester channels and the NB cache banks inside the multi-port cache.
- Steers each channel request to its bank, using the bank-select address bits.
- Arbitrates round-robin per bank and registers one request per bank toward the bank pipeline.
- Routes bank responses back to the originating channel using the channel id that travels with each request.

---
 rtl/mpc_chan_bank_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mpc_chan_bank_arb.sv
// Channel-to-bank request steering with per-bank round-robin arbitration and a
// one-entry request register per bank; responses are routed back by channel id.
module mpc_chan_bank_arb #(
    parameter int unsigned NCH      = 3,
    parameter int unsigned NB       = 4,
    parameter int unsigned OP_W     = 3,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned BANK_LSB = 5,
    parameter int unsigned CHID_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          ch_req_valid,
    output logic [NCH-1:0]          ch_req_ready,
    input  logic [NCH*OP_W-1:0]     ch_req_op,
    input  logic [NCH*ADDR_W-1:0]   ch_req_addr,
    input  logic [NCH*DATA_W-1:0]   ch_req_wdata,
    output logic [NB-1:0]           bank_req_valid,
    input  logic [NB-1:0]           bank_req_ready,
    output logic [NB*OP_W-1:0]      bank_req_op,
    output logic [NB*ADDR_W-1:0]    bank_req_addr,
    output logic [NB*DATA_W-1:0]    bank_req_wdata,
    output logic [NB*CHID_W-1:0]    bank_req_chid,
    input  logic [NB-1:0]           bank_rsp_valid,
    output logic [NB-1:0]           bank_rsp_ready,
    input  logic [NB*CHID_W-1:0]    bank_rsp_chid,
    input  logic [NB*DATA_W-1:0]    bank_rsp_rdata,
    output logic [NCH-1:0]          ch_rsp_valid,
    input  logic [NCH-1:0]          ch_rsp_ready,
    output logic [NCH*DATA_W-1:0]   ch_rsp_rdata,
    output logic                    rsp_err
);

    localparam int unsigned SEL_W = $clog2(NB);

    logic [NB-1:0]              r_req_valid;
    logic [NB*OP_W-1:0]         r_req_op;
    logic [NB*ADDR_W-1:0]       r_req_addr;
    logic [NB*DATA_W-1:0]       r_req_wdata;
    logic [NB*CHID_W-1:0]       r_req_chid;
    logic [NB-1:0][CHID_W-1:0]  r_ptr;
    logic                       r_rsp_err;

    logic [NCH-1:0][SEL_W-1:0]  w_sel;
    logic [NB-1:0]              w_load;
    logic [NB-1:0]              w_gnt_any;
    logic [NB-1:0][CHID_W-1:0]  w_gnt_idx;
    logic [NB-1:0][OP_W-1:0]    w_gnt_op;
    logic [NB-1:0][ADDR_W-1:0]  w_gnt_addr;
    logic [NB-1:0][DATA_W-1:0]  w_gnt_wdata;
    logic [NCH-1:0]             w_ch_ready;

    logic [NCH-1:0]             w_rsp_valid;
    logic [NCH*DATA_W-1:0]      w_rsp_rdata;
    logic [NB-1:0]              w_bank_rsp_ready;
    logic                       w_illegal;

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            w_sel[c] = ch_req_addr[c*ADDR_W + BANK_LSB +: SEL_W];
        end
    end

    // Scan channels starting at the bank's pointer; first matching candidate wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        w_load      = '0;
        w_gnt_any   = '0;
        w_gnt_idx   = '0;
        w_gnt_op    = '0;
        w_gnt_addr  = '0;
        w_gnt_wdata = '0;
        w_ch_ready  = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            w_load[b] = !r_req_valid[b] || bank_req_ready[b];
            for (int unsigned k = 0; k < NCH; k++) begin
                idx = (32'(r_ptr[b]) + k) % NCH;
                if (rst_n && w_load[b] && !w_gnt_any[b] && ch_req_valid[idx] &&
                    (w_sel[idx] == SEL_W'(b))) begin
                    w_gnt_any[b]   = 1'b1;
                    w_gnt_idx[b]   = CHID_W'(idx);
                    w_gnt_op[b]    = ch_req_op[idx*OP_W +: OP_W];
                    w_gnt_addr[b]  = ch_req_addr[idx*ADDR_W +: ADDR_W];
                    w_gnt_wdata[b] = ch_req_wdata[idx*DATA_W +: DATA_W];
                    w_ch_ready[idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_valid <= '0;
            r_req_op    <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_chid  <= '0;
            r_ptr       <= '0;
        end else begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (w_gnt_any[b]) begin
                    r_req_valid[b]                <= 1'b1;
                    r_req_op[b*OP_W +: OP_W]       <= w_gnt_op[b];
                    r_req_addr[b*ADDR_W +: ADDR_W] <= w_gnt_addr[b];
                    r_req_wdata[b*DATA_W +: DATA_W] <= w_gnt_wdata[b];
                    r_req_chid[b*CHID_W +: CHID_W] <= w_gnt_idx[b];
                    r_ptr[b] <= (w_gnt_idx[b] == CHID_W'(NCH-1)) ? '0
                                                                   : w_gnt_idx[b] + CHID_W'(1);
                end else if (bank_req_ready[b]) begin
                    r_req_valid[b] <= 1'b0;
                end
            end
        end
    end

    // Illegal ids are sunk unconditionally; legal ones go to the lowest-index bank per channel.
    always_comb begin
        w_rsp_valid      = '0;
        w_rsp_rdata      = '0;
        w_bank_rsp_ready = '0;
        w_illegal        = 1'b0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (bank_rsp_valid[b] && (32'(bank_rsp_chid[b*CHID_W +: CHID_W]) >= NCH)) begin
                w_bank_rsp_ready[b] = 1'b1;
                w_illegal           = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (!w_rsp_valid[c] && bank_rsp_valid[b] &&
                    (bank_rsp_chid[b*CHID_W +: CHID_W] == CHID_W'(c))) begin
                    w_rsp_valid[c]                  = 1'b1;
                    w_rsp_rdata[c*DATA_W +: DATA_W] = bank_rsp_rdata[b*DATA_W +: DATA_W];
                    w_bank_rsp_ready[b]             = ch_rsp_ready[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_illegal;
        end
    end

    assign ch_req_ready   = w_ch_ready;
    assign bank_req_valid = r_req_valid;
    assign bank_req_op    = r_req_op;
    assign bank_req_addr  = r_req_addr;
    assign bank_req_wdata = r_req_wdata;
    assign bank_req_chid  = r_req_chid;
    assign bank_rsp_ready = w_bank_rsp_ready;
    assign ch_rsp_valid   = w_rsp_valid;
    assign ch_rsp_rdata   = w_rsp_rdata;
    assign rsp_err        = r_rsp_err;

endmodule
